// File: rtl/xy_router_if.sv
// Port bundle of the 5-port mesh router: per-port ingress write channel and
// egress read channel, each port owning one PACKET_WIDTH slice of the data buses.
interface xy_router_if #(
   parameter int PACKET_WIDTH = 16
);
   logic [5*PACKET_WIDTH-1:0] i_data;
   logic [4:0]                i_wr_valid;
   logic [4:0]                o_wr_fifoReady;
   logic [5*PACKET_WIDTH-1:0] o_data;
   logic [4:0]                o_rd_valid;
   logic [4:0]                i_rd_fifoReady;

   modport slave (
      input  i_data, i_wr_valid, i_rd_fifoReady,
      output o_wr_fifoReady, o_data, o_rd_valid
   );

   modport master (
      output i_data, i_wr_valid, i_rd_fifoReady,
      input  o_wr_fifoReady, o_data, o_rd_valid
   );
endinterface

// File: rtl/xy_router_switch.sv
// 5-port mesh switch: per-input FIFO, dimension-ordered route (XY or YX),
// per-output round-robin arbiter feeding a 1-deep output register.
module xy_router_switch #(
   parameter int PACKET_WIDTH = 16,
   parameter int X_BITS       = 2,
   parameter int Y_BITS       = 2,
   parameter int X_COORD      = 0,
   parameter int Y_COORD      = 0,
   parameter int FIFO_DEPTH   = 4,
   parameter int ROUTE_MODE   = 0
) (
   input logic        clk,
   input logic        i_reset_n,
   xy_router_if.slave bus
);
   localparam int NP = 5;
   localparam int PW = PACKET_WIDTH;
   localparam int HW = X_BITS + Y_BITS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [X_BITS-1:0] XC = X_BITS'(X_COORD);
   localparam logic [Y_BITS-1:0] YC = Y_BITS'(Y_COORD);

   logic [PW-1:0] mem_q   [NP][FIFO_DEPTH];
   logic [PW-1:0] mem_d   [NP][FIFO_DEPTH];
   logic [AW-1:0] wptr_q  [NP];
   logic [AW-1:0] wptr_d  [NP];
   logic [AW-1:0] rptr_q  [NP];
   logic [AW-1:0] rptr_d  [NP];
   logic [CW-1:0] cnt_q   [NP];
   logic [CW-1:0] cnt_d   [NP];
   logic [2:0]    rr_q    [NP];
   logic [2:0]    rr_d    [NP];
   logic [PW-1:0] odata_q [NP];
   logic [PW-1:0] odata_d [NP];
   logic [NP-1:0] ovld_q, ovld_d;
   logic [NP-1:0] rdy_q, rdy_d;

   logic [PW-1:0]    head [NP];
   logic [2:0]       dst  [NP];
   logic [NP-1:0]    pop;
   logic [NP*PW-1:0] odata_flat;

   function automatic logic [2:0] route(input logic [HW-1:0] hdr);
      logic [X_BITS-1:0] dx;
      logic [Y_BITS-1:0] dy;
      dx = hdr[HW-1 -: X_BITS];
      dy = hdr[Y_BITS-1:0];
      if (ROUTE_MODE == 0) begin
         if (dx > XC)      return 3'd1;
         else if (dx < XC) return 3'd0;
         else if (dy > YC) return 3'd2;
         else if (dy < YC) return 3'd3;
         else              return 3'd4;
      end else begin
         if (dy > YC)      return 3'd2;
         else if (dy < YC) return 3'd3;
         else if (dx > XC) return 3'd1;
         else if (dx < XC) return 3'd0;
         else              return 3'd4;
      end
   endfunction

   always_comb begin
      logic       found;
      logic       push;
      logic [2:0] sel;
      found   = 1'b0;
      push    = 1'b0;
      sel     = 3'd0;
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      odata_d = odata_q;
      ovld_d  = ovld_q;
      rdy_d   = rdy_q;
      pop     = '0;

      for (int p = 0; p < NP; p++) begin
         head[p] = mem_q[p][rptr_q[p]];
         dst[p]  = route(head[p][PW-1 -: HW]);
      end

      // Each input routes to exactly one output, so one grant per input is implicit.
      for (int q = 0; q < NP; q++) begin
         if (!ovld_q[q] || bus.i_rd_fifoReady[q]) begin
            ovld_d[q] = 1'b0;
            found     = 1'b0;
            for (int i = 0; i < NP; i++) begin
               sel = 3'((int'(rr_q[q]) + i) % NP);
               if (!found && cnt_q[sel] != '0 && dst[sel] == 3'(q)) begin
                  found      = 1'b1;
                  pop[sel]   = 1'b1;
                  ovld_d[q]  = 1'b1;
                  odata_d[q] = head[sel];
                  rr_d[q]    = (sel == 3'(NP-1)) ? 3'd0 : sel + 3'd1;
               end
            end
         end
      end

      for (int p = 0; p < NP; p++) begin
         push = bus.i_wr_valid[p] && rdy_q[p];
         if (push) begin
            mem_d[p][wptr_q[p]] = bus.i_data[p*PW +: PW];
            wptr_d[p]           = wptr_q[p] + 1'b1;
         end
         if (pop[p]) rptr_d[p] = rptr_q[p] + 1'b1;
         case ({push, pop[p]})
            2'b10:   cnt_d[p] = cnt_q[p] + 1'b1;
            2'b01:   cnt_d[p] = cnt_q[p] - 1'b1;
            default: cnt_d[p] = cnt_q[p];
         endcase
         // Registered so a same-cycle pop never raises ready early.
         rdy_d[p] = cnt_d[p] < CW'(FIFO_DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         wptr_q  <= '{default: '0};
         rptr_q  <= '{default: '0};
         cnt_q   <= '{default: '0};
         rr_q    <= '{default: '0};
         odata_q <= '{default: '0};
         ovld_q  <= '0;
         rdy_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         odata_q <= odata_d;
         ovld_q  <= ovld_d;
         rdy_q   <= rdy_d;
      end
      mem_q <= mem_d;
   end

   always_comb begin
      odata_flat = '0;
      for (int q = 0; q < NP; q++) odata_flat[q*PW +: PW] = odata_q[q];
   end

   assign bus.o_data         = odata_flat;
   assign bus.o_rd_valid     = ovld_q;
   assign bus.o_wr_fifoReady = rdy_q;
endmodule

// File: tb/tb_xy_router_switch.sv
// Directed bench: routing vector table on an XY and a YX instance, plus
// arbitration, backpressure and mid-traffic reset sequences.
module tb_xy_router_switch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [79:0] in_data;
   logic [4:0]  in_vld;
   logic [4:0]  rd_rdy;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   xy_router_if #(.PACKET_WIDTH(16)) if0 ();
   xy_router_if #(.PACKET_WIDTH(16)) if1 ();

   assign if0.i_data         = in_data;
   assign if0.i_wr_valid     = in_vld;
   assign if0.i_rd_fifoReady = rd_rdy;
   assign if1.i_data         = in_data;
   assign if1.i_wr_valid     = in_vld;
   assign if1.i_rd_fifoReady = rd_rdy;

   xy_router_switch #(.X_COORD(1), .Y_COORD(1), .ROUTE_MODE(0)) dut_xy (
      .clk(clk), .i_reset_n(rst_n), .bus(if0));
   xy_router_switch #(.X_COORD(1), .Y_COORD(1), .ROUTE_MODE(1)) dut_yx (
      .clk(clk), .i_reset_n(rst_n), .bus(if1));

   typedef struct {
      int          port;
      logic [15:0] pkt;
      int          exy;
      int          eyx;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      in_vld = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [15:0] exp_q [$];
      vecs[0] = '{0, 16'h2ABC, 0, 2};
      vecs[1] = '{4, 16'h5123, 4, 4};
      vecs[2] = '{0, 16'hA000, 1, 2};
      vecs[3] = '{2, 16'h4000, 3, 3};
      vecs[4] = '{3, 16'hC7FF, 1, 3};
      vecs[5] = '{1, 16'h1234, 0, 0};
      vecs[6] = '{4, 16'h7000, 2, 2};
      vecs[7] = '{0, 16'h3000, 0, 2};

      rst_n   = 1'b0;
      in_data = '0;
      in_vld  = '0;
      rd_rdy  = 5'h1f;
      tick();
      tick();
      check("reset_valid", 80'(if0.o_rd_valid), 80'(5'h00));
      check("reset_ready", 80'(if0.o_wr_fifoReady), 80'(5'h00));
      check("reset_data", if0.o_data, 80'h0);
      rst_n = 1'b1;
      tick();
      check("ready_after_release", 80'(if0.o_wr_fifoReady), 80'(5'h1f));

      // Routing table: written at edge k, visible after edge k+1.
      for (int v = 0; v < 8; v++) begin
         in_data                     = '0;
         in_data[vecs[v].port*16 +: 16] = vecs[v].pkt;
         in_vld                      = 5'(1) << vecs[v].port;
         tick();
         in_vld = '0;
         tick();
         check($sformatf("xy_valid_v%0d", v), 80'(if0.o_rd_valid), 80'(5'(1) << vecs[v].exy));
         check($sformatf("xy_data_v%0d", v), 80'(if0.o_data[vecs[v].exy*16 +: 16]), 80'(vecs[v].pkt));
         check($sformatf("yx_valid_v%0d", v), 80'(if1.o_rd_valid), 80'(5'(1) << vecs[v].eyx));
         check($sformatf("yx_data_v%0d", v), 80'(if1.o_data[vecs[v].eyx*16 +: 16]), 80'(vecs[v].pkt));
         tick();
         check($sformatf("idle_v%0d", v), 80'(if0.o_rd_valid), 80'(5'h00));
      end

      // Round-robin: inputs 0,2,3 each queue 3 packets for the PE port.
      do_reset();
      rd_rdy = 5'h0f;
      for (int k = 0; k < 3; k++) begin
         in_data = '0;
         in_data[0*16 +: 16] = 16'h5000 + 16'(k);
         in_data[2*16 +: 16] = 16'h5020 + 16'(k);
         in_data[3*16 +: 16] = 16'h5030 + 16'(k);
         in_vld = 5'b01101;
         tick();
      end
      in_vld = '0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(16'h5000 + 16'(k));
         exp_q.push_back(16'h5020 + 16'(k));
         exp_q.push_back(16'h5030 + 16'(k));
      end
      check("rr_held_valid", 80'(if0.o_rd_valid[4]), 80'(1'b1));
      check("rr_held_data", 80'(if0.o_data[64 +: 16]), 80'(exp_q.pop_front()));
      rd_rdy = 5'h1f;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("rr_order_%0d", k), 80'({if0.o_rd_valid[4], if0.o_data[64 +: 16]}),
               80'({1'b1, exp_q.pop_front()}));
      end
      tick();
      check("rr_done", 80'(if0.o_rd_valid), 80'(5'h00));

      // Backpressure: 6 packets for port 1 from the left while port 1 stalls.
      do_reset();
      rd_rdy  = 5'h1d;
      in_vld  = 5'b00001;
      for (int k = 0; k < 6; k++) begin
         in_data = '0;
         in_data[15:0] = 16'h8000 + 16'(k);
         tick();
         if (k == 4) check("bp_ready_low_after_5", 80'(if0.o_wr_fifoReady[0]), 80'(1'b0));
      end
      in_vld = '0;
      check("bp_ready_low", 80'(if0.o_wr_fifoReady[0]), 80'(1'b0));
      check("bp_held", 80'({if0.o_rd_valid[1], if0.o_data[16 +: 16]}), 80'({1'b1, 16'h8000}));
      tick();
      check("bp_stable", 80'({if0.o_rd_valid[1], if0.o_data[16 +: 16]}), 80'({1'b1, 16'h8000}));
      rd_rdy = 5'h1f;
      for (int k = 1; k < 5; k++) begin
         tick();
         check($sformatf("bp_drain_%0d", k), 80'({if0.o_rd_valid[1], if0.o_data[16 +: 16]}),
               80'({1'b1, 16'h8000 + 16'(k)}));
      end
      tick();
      check("bp_no_sixth", 80'(if0.o_rd_valid), 80'(5'h00));
      check("bp_ready_back", 80'(if0.o_wr_fifoReady), 80'(5'h1f));

      // Mid-traffic reset with every FIFO holding packets.
      rd_rdy = 5'h00;
      in_vld = 5'h1f;
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 5; p++) in_data[p*16 +: 16] = (k[0] ? 16'h5000 : 16'h0000) + 16'(p);
         tick();
      end
      in_vld = '0;
      rst_n  = 1'b0;
      tick();
      check("mid_reset_valid", 80'(if0.o_rd_valid), 80'(5'h00));
      check("mid_reset_ready", 80'(if0.o_wr_fifoReady), 80'(5'h00));
      check("mid_reset_data", if0.o_data, 80'h0);
      rst_n = 1'b1;
      tick();
      check("mid_release_ready", 80'(if0.o_wr_fifoReady), 80'(5'h1f));
      rd_rdy = 5'h1f;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("no_stale_%0d", k), 80'(if0.o_rd_valid), 80'(5'h00));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
